// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq block: op-code constants and FSM state encoding.
// The iterative multiplier is only present when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master = operand source and result sink; slave = the ALU itself.
interface alu_seq_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [W-1:0] yh;
  logic         fz;
  logic         fn;
  logic         fc;
  logic         fv;

  modport master (
    output in_valid, op, a, b, ci, out_ready,
    input  in_ready, out_valid, y, yh, fz, fn, fc, fv
  );

  modport slave (
    input  in_valid, op, a, b, ci, out_ready,
    output in_ready, out_valid, y, yh, fz, fn, fc, fv
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier, one partial product per cycle, W steps per product.
// 'done' and 'p' are combinational views of the final step so the parent can
// capture the product on the same edge the last step completes.
// Only instantiated when ALU_SEQ_MUL_EN is defined.
module alu_seq_mul #(
  parameter int W  = 8,
  parameter int CW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] p
);

  logic           busy;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;
  logic [2*W-1:0] addend;

  // Partial product for the current step: multiplicand already shifted to bit cnt.
  always_comb begin
    addend = b_sh[0] ? a_sh : '0;
    p      = prod + addend;
    done   = busy && (cnt == CW'(W - 1));
  end

  // Latch operands on start, then accumulate one multiplier bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      prod <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      prod <= '0;
      a_sh <= {{W{1'b0}}, a};
      b_sh <= b;
    end else if (busy) begin
      prod <= p;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked W-bit ALU with flags and a one-entry output register.
// Single-cycle ops: pass/add/sub/and/or/xor/reserved.
// Define ALU_SEQ_MUL_EN to enable the iterative multiply on op 011;
// otherwise op 011 behaves like the reserved op.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 6
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);

  // The multiply counter must be able to count W steps.
  if ((2 ** CW) <= W) begin : g_bad_cw
    $error("alu_seq: CW too small for W");
  end

  state_t       state;
  logic         out_valid_q;
  logic [W-1:0] y_q;
  logic [W-1:0] yh_q;
  logic         fz_q;
  logic         fn_q;
  logic         fc_q;
  logic         fv_q;

  logic         in_xfer;
  logic         out_xfer;
  logic [W-1:0] res_y;
  logic         res_c;
  logic         res_v;
  logic [W:0]   sum;
  logic [W:0]   diff;

`ifdef ALU_SEQ_MUL_EN
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_p;

  assign mul_start = in_xfer && (bus.op == OP_MUL);

  alu_seq_mul #(
    .W  (W),
    .CW (CW)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .p     (mul_p)
  );
`endif

  // Accept only when idle and the output slot is free or draining this cycle.
  assign bus.in_ready  = !reset && (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign out_xfer      = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.yh        = yh_q;
  assign bus.fz        = fz_q;
  assign bus.fn        = fn_q;
  assign bus.fc        = fc_q;
  assign bus.fv        = fv_q;

  // Single-cycle result and carry/overflow for the op presented on the bus.
  always_comb begin
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    sum   = '0;
    diff  = '0;
    case (bus.op)
      OP_PASS: res_y = bus.a;
      OP_ADD: begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.ci};
        res_y = sum[W-1:0];
        res_c = sum[W];
        res_v = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        diff  = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, bus.ci};
        res_y = diff[W-1:0];
        res_c = diff[W];
        res_v = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
      end
      OP_AND:  res_y = bus.a & bus.b;
      OP_OR:   res_y = bus.a | bus.b;
      OP_XOR:  res_y = bus.a ^ bus.b;
      default: res_y = '0;
    endcase
  end

  // Control FSM and output register: load results, hold under back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      yh_q        <= '0;
      fz_q        <= 1'b0;
      fn_q        <= 1'b0;
      fc_q        <= 1'b0;
      fv_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_xfer) begin
`ifdef ALU_SEQ_MUL_EN
            if (bus.op == OP_MUL) begin
              state       <= ST_MUL;
              out_valid_q <= 1'b0;
            end else begin
              y_q         <= res_y;
              yh_q        <= '0;
              fz_q        <= (res_y == '0);
              fn_q        <= res_y[W-1];
              fc_q        <= res_c;
              fv_q        <= res_v;
              out_valid_q <= 1'b1;
            end
`else
            y_q         <= res_y;
            yh_q        <= '0;
            fz_q        <= (res_y == '0);
            fn_q        <= res_y[W-1];
            fc_q        <= res_c;
            fv_q        <= res_v;
            out_valid_q <= 1'b1;
`endif
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            y_q         <= mul_p[W-1:0];
            yh_q        <= mul_p[2*W-1:W];
            fz_q        <= (mul_p == '0);
            fn_q        <= mul_p[2*W-1];
            fc_q        <= (mul_p[2*W-1:W] != '0);
            fv_q        <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=4.
// Expectations for op 011 depend on whether ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(
    .W  (W),
    .CW (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one operand set and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [3:0] ai,
                               input logic [3:0] bi, input logic c, input logic rdy);
    bus.in_valid  = v;
    bus.op        = o;
    bus.a         = ai;
    bus.b         = bi;
    bus.ci        = c;
    bus.out_ready = rdy;
    #1;
  endtask

  // Advance past the next rising edge; outputs are sampled 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One comparison of an observed value against a hand-computed one.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkFlags(input string tag, input logic z, input logic n,
                            input logic c, input logic v);
    checkOutput({tag, "_fz"}, {7'd0, bus.fz}, {7'd0, z});
    checkOutput({tag, "_fn"}, {7'd0, bus.fn}, {7'd0, n});
    checkOutput({tag, "_fc"}, {7'd0, bus.fc}, {7'd0, c});
    checkOutput({tag, "_fv"}, {7'd0, bus.fv}, {7'd0, v});
  endtask

  initial begin
    logic [3:0] ea;
    logic [3:0] eb;
    checks = 0;
    passes = 0;

    // Reset: in_ready low during reset, all outputs cleared.
    reset = 1'b1;
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd1, 1'b0, 1'b1);
    checkOutput("rst_in_ready", {7'd0, bus.in_ready}, 8'd0);
    step();
    step();
    checkOutput("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    checkOutput("rst_y", {4'd0, bus.y}, 8'd0);
    checkOutput("rst_yh", {4'd0, bus.yh}, 8'd0);
    checkFlags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b1);
    checkOutput("idle_in_ready", {7'd0, bus.in_ready}, 8'd1);

    // Add 7+9 wraps to 0 with carry; 7+1 overflows signed.
    applyStimulus(1'b1, OP_ADD, 4'd7, 4'd9, 1'b0, 1'b1);
    step();
    checkOutput("add79_valid", {7'd0, bus.out_valid}, 8'd1);
    checkOutput("add79_y", {4'd0, bus.y}, 8'h00);
    checkFlags("add79", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_ADD, 4'd7, 4'd1, 1'b0, 1'b1);
    step();
    checkOutput("add71_y", {4'd0, bus.y}, 8'h08);
    checkFlags("add71", 1'b0, 1'b1, 1'b0, 1'b1);

    // Sub 3-5 borrows; 5-5-1 borrows to all ones.
    applyStimulus(1'b1, OP_SUB, 4'd3, 4'd5, 1'b0, 1'b1);
    step();
    checkOutput("sub35_y", {4'd0, bus.y}, 8'h0E);
    checkFlags("sub35", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_SUB, 4'd5, 4'd5, 1'b1, 1'b1);
    step();
    checkOutput("sub551_y", {4'd0, bus.y}, 8'h0F);
    checkFlags("sub551", 1'b0, 1'b1, 1'b1, 1'b0);

    // Pass and reserved.
    applyStimulus(1'b1, OP_PASS, 4'hB, 4'h3, 1'b0, 1'b1);
    step();
    checkOutput("pass_y", {4'd0, bus.y}, 8'h0B);
    checkOutput("pass_yh", {4'd0, bus.yh}, 8'h00);
    applyStimulus(1'b1, OP_RSV, 4'hB, 4'h3, 1'b1, 1'b1);
    step();
    checkOutput("rsv_y", {4'd0, bus.y}, 8'h00);
    checkFlags("rsv", 1'b1, 1'b0, 1'b0, 1'b0);

    // Logic sweep at full throughput.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        ea = 4'(i % 4);
        eb = 4'(i / 4);
        applyStimulus(1'b1, (k == 0) ? OP_AND : ((k == 1) ? OP_OR : OP_XOR), ea, eb, 1'b0, 1'b1);
        checkOutput("sweep_in_ready", {7'd0, bus.in_ready}, 8'd1);
        step();
        checkOutput("sweep_y", {4'd0, bus.y},
                    {4'd0, (k == 0) ? (ea & eb) : ((k == 1) ? (ea | eb) : (ea ^ eb))});
      end
    end

    // Back-pressure: xor result held while the sink stalls, then an add rides the drain.
    applyStimulus(1'b1, OP_XOR, 4'hC, 4'hA, 1'b0, 1'b1);
    step();
    checkOutput("bp_y0", {4'd0, bus.y}, 8'h06);
    applyStimulus(1'b1, OP_ADD, 4'd2, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_in_ready", {7'd0, bus.in_ready}, 8'd0);
      checkOutput("bp_valid", {7'd0, bus.out_valid}, 8'd1);
      step();
      checkOutput("bp_y_hold", {4'd0, bus.y}, 8'h06);
    end
    applyStimulus(1'b1, OP_ADD, 4'd2, 4'd3, 1'b0, 1'b1);
    checkOutput("bp_release_ready", {7'd0, bus.in_ready}, 8'd1);
    step();
    checkOutput("bp_add_y", {4'd0, bus.y}, 8'h05);
    checkOutput("bp_add_valid", {7'd0, bus.out_valid}, 8'd1);
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b1);
    step();
    checkOutput("drain_valid", {7'd0, bus.out_valid}, 8'd0);

    // Multiply 15*15.
    applyStimulus(1'b1, OP_MUL, 4'hF, 4'hF, 1'b0, 1'b1);
    checkOutput("mul_in_ready", {7'd0, bus.in_ready}, 8'd1);
    step();
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b1);
`ifdef ALU_SEQ_MUL_EN
    for (int i = 0; i < 4; i++) begin
      checkOutput("mul_busy_ready", {7'd0, bus.in_ready}, 8'd0);
      checkOutput("mul_busy_valid", {7'd0, bus.out_valid}, 8'd0);
      step();
    end
    checkOutput("mul_valid", {7'd0, bus.out_valid}, 8'd1);
    checkOutput("mul_y", {4'd0, bus.y}, 8'h01);
    checkOutput("mul_yh", {4'd0, bus.yh}, 8'h0E);
    checkFlags("mul", 1'b0, 1'b1, 1'b1, 1'b0);
`else
    checkOutput("mulrsv_valid", {7'd0, bus.out_valid}, 8'd1);
    checkOutput("mulrsv_y", {4'd0, bus.y}, 8'h00);
    checkOutput("mulrsv_yh", {4'd0, bus.yh}, 8'h00);
    checkFlags("mulrsv", 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    step();
    checkOutput("mul_drain_valid", {7'd0, bus.out_valid}, 8'd0);

    // Reset in the middle of a multiply aborts it.
    applyStimulus(1'b1, OP_MUL, 4'hF, 4'hF, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b1);
    step();
    reset = 1'b1;
    #1;
    step();
    checkOutput("abort_valid", {7'd0, bus.out_valid}, 8'd0);
    checkOutput("abort_y", {4'd0, bus.y}, 8'h00);
    checkOutput("abort_yh", {4'd0, bus.yh}, 8'h00);
    checkFlags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, OP_ADD, 4'd2, 4'd2, 1'b0, 1'b1);
    checkOutput("post_rst_ready", {7'd0, bus.in_ready}, 8'd1);
    step();
    checkOutput("post_rst_y", {4'd0, bus.y}, 8'h04);
    checkOutput("post_rst_valid", {7'd0, bus.out_valid}, 8'd1);
`ifdef ALU_SEQ_MUL_EN
    // Stay idle for the remaining aborted-multiply cycles: no spurious result.
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("post_rst_quiet", {7'd0, bus.out_valid}, 8'd0);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the combinational W-bit ALU (add/sub/and/or/xor).
- Adds registered valid/ready input and output, status flags, and an iterative multi-cycle multiply op.
- One-entry output register; sits between an operand source (sequencer/decoder) and a result sink that may stall.

Parameters:
- W, 8, operand/result width (W >= 2)
- CW, 6, multiply iteration counter width; must satisfy 2^CW > W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block accepts operands this cycle
- op  in  3  operation code
- a  in  W  operand A
- b  in  W  operand B
- ci  in  1  carry-in (add) / borrow-in (sub)
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- y  out  W  result (low half for mul)
- yh  out  W  high half of product; 0 for non-mul ops
- fz  out  1  zero flag
- fn  out  1  negative flag (MSB of y; of yh for mul)
- fc  out  1  carry/borrow out
- fv  out  1  signed overflow

Behaviour:
- Op codes:
  - 000: pass a
  - 001: add, a+b+ci
  - 010: sub, a-b-ci
  - 011: mul, unsigned a*b, 2W-bit result on {yh,y}
  - 100: and
  - 101: or
  - 110: xor
  - 111: reserved, y=0
- Reset: state IDLE; out_valid=0; y=yh=0; fz=fn=fc=fv=0; in_ready=0 during the reset cycle.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- FSM states:
  - IDLE: in_ready = !out_valid | out_ready. A single-cycle op transfers at cycle t -> result registered, out_valid=1 at t+1. A mul transfers -> go to MUL, latch a, b, clear product, cnt=0.
  - MUL: in_ready=0. One shift-add step per cycle (if b[cnt], product += a<<cnt). After W steps, write the result and set out_valid; go to IDLE. Result is visible W+1 cycles after acceptance.
- Back-to-back: a new op may be accepted in the same cycle the current result transfers, giving full throughput for single-cycle ops.
- Output hold: while out_valid & !out_ready, y/yh/flags and out_valid are held stable; in_ready=0.
- Arithmetic:
  - add: fc = carry out of bit W-1.
  - sub: fc = borrow out (1 when a < b+ci unsigned).
  - fv: signed two's-complement overflow for add/sub; 0 for all other ops.
  - Logic/pass/reserved: fc=fv=0.
  - mul: fc = (yh != 0); fv=0; fz = ({yh,y} == 0).
  - All other ops: fz = (y == 0).
- Wrap-around: results are modulo 2^W; no saturation.
- in_valid while in_ready=0 is ignored; the source must hold its inputs.
- Reset asserted in any state (including mid-MUL) aborts the operation and applies reset values on the next edge.
- out_valid never drops without an output transfer, except on reset.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 011 is the iterative multiplier described above.
- Undefined: no MUL state or multiplier logic; op 011 behaves like reserved (1-cycle, y=yh=0, fz=1, others 0).

Decomposition:
- Package alu_seq_pkg: op-code constants (OP_PASS, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_RSV) and state encoding (ST_IDLE, ST_MUL).
- One sub-module, alu_seq_mul: shift-add multiplier.
  - Ports: clk, reset, start, a, b, done, p[2W-1:0].
  - Instantiated only under ALU_SEQ_MUL_EN.

Test Plan (W=4):
- add, a=7 b=9 ci=0, out_ready=1 -> next cycle y=0, fc=1, fz=1, fv=0; a=7 b=1 -> y=8, fn=1, fv=1.
- sub, a=3 b=5 ci=0 -> y=0xE, fc=1, fn=1; a=5 b=5 ci=1 -> y=0xF, fc=1.
- Logic sweep and/or/xor: a=i%4, b=i/4 for i=0..15, one op per cycle with out_ready=1 -> in_ready stays 1 and results match the bitwise function at t+1.
- Back-pressure: out_ready=0 for 3 cycles after xor a=0xC b=0xA -> y=6 held, in_ready=0; out_ready=1 -> transfer, and a queued add is accepted in the same cycle.
- mul (MUL_EN), a=15 b=15 at t -> out_valid at t+5 with yh=0xE, y=0x1, fc=1, fn=1; in_ready=0 for t+1..t+4. Without the macro -> y=yh=0, fz=1 at t+1.
- Reset asserted at t+2 of a mul -> out_valid=0, all outputs 0 at t+3; after release, in_ready=1 and an add 2+2 -> y=4.
